// File: rtl/std_sync_fifo.sv
// -----------------------------------------------------------------------------
// std_sync_fifo
//   Single-clock circular-buffer FIFO used throughout the SpMV processing
//   element (decoder/x-cache requests, matrix values, row indices, x values,
//   MAC results, merged memory requests).
//
//   Read latency is selected by LATENCY:
//     1 - q is a register loaded from the head entry on the edge of an
//         accepted pop; data is usable the cycle after the pop.
//     0 - first-word fall-through; q shows the head entry combinationally
//         whenever empty=0 (don't-care while empty).
//
//   Optional build macro: STD_SYNC_FIFO_CHECK_EN
//     When defined, simulation-only overflow/underflow messages and a count
//     range check are compiled in. Datapath behaviour is identical either way.
//
// Ports
//   rst           in   1        synchronous reset, active high
//   clk           in   1        clock, rising edge
//   push          in   1        write d this cycle
//   pop           in   1        consume head entry this cycle
//   d             in   WIDTH    write data
//   q             out  WIDTH    read data
//   full          out  1        count == DEPTH
//   empty         out  1        count == 0
//   count         out  AW+1     occupancy 0..DEPTH
//   almost_empty  out  1        count <= ALMOST_EMPTY_COUNT
//   almost_full   out  1        count >= DEPTH - ALMOST_FULL_COUNT
// -----------------------------------------------------------------------------
module std_sync_fifo #(
  parameter int WIDTH              = 64,
  parameter int DEPTH              = 32,
  parameter int ALMOST_FULL_COUNT  = 4,
  parameter int ALMOST_EMPTY_COUNT = 1,
  parameter int LATENCY            = 1,
  localparam int AW                = $clog2(DEPTH)
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             almost_empty,
  output logic             almost_full
);

  localparam int CW = AW + 1;

  // Thresholds are clamped so that out-of-range parameters still decode
  // sensibly: an almost-full margin >= DEPTH makes almost_full always set.
  localparam logic [AW:0] AF_LEVEL = (DEPTH > ALMOST_FULL_COUNT) ?
                                     CW'(DEPTH - ALMOST_FULL_COUNT) : '0;
  localparam logic [AW:0] AE_LEVEL = (ALMOST_EMPTY_COUNT >= DEPTH) ?
                                     CW'(DEPTH) : CW'(ALMOST_EMPTY_COUNT);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg,  count_next;

  logic pop_eff;
  logic push_eff;

  // Flags decode from the registered count only.
  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign count        = count_reg;
  assign almost_empty = (count_reg <= AE_LEVEL);
  assign almost_full  = (count_reg >= AF_LEVEL);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_eff) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop_eff) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    count_next = count_reg + CW'(push_eff) - CW'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is never reset so it can map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && push_eff) begin
      mem[wr_ptr_reg] <= d;
    end
  end

  generate
    if (LATENCY == 1) begin : g_reg_q
      logic [WIDTH-1:0] q_reg;

      // On a full push+pop wr_ptr == rd_ptr; the read sees the old head
      // because both accesses happen on the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= '0;
        end else if (pop_eff) begin
          q_reg <= mem[rd_ptr_reg];
        end
      end

      assign q = q_reg;
    end else begin : g_fwft
      assign q = mem[rd_ptr_reg];
    end
  endgenerate

`ifdef STD_SYNC_FIFO_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push && full && !pop) begin
        $display("%m: overflow at time %0t", $time);
      end
      if (pop && empty) begin
        $display("%m: underflow at time %0t", $time);
      end
      if (count_reg > CW'(DEPTH)) begin
        $stop;
      end
    end
  end
`endif

endmodule

// File: tb/tb_std_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_std_sync_fifo
//   Drives one LATENCY=1 and one LATENCY=0 instance (DEPTH=32, AFC=4, AEC=1)
//   with identical stimulus and compares both against a queue-based model of
//   FIFO behaviour. Directed steps cover reset, ordering, almost/full limits,
//   full push+pop wraparound, fall-through reads, empty pops and reset during
//   traffic; a randomized phase with shifting push/pop bias follows.
// -----------------------------------------------------------------------------
module tb_std_sync_fifo;

  localparam int W  = 64;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic          push = 1'b0;
  logic          pop  = 1'b0;
  logic [W-1:0]  d    = '0;

  logic [W-1:0]  q1, q0;
  logic          full1, empty1, ae1, af1;
  logic          full0, empty0, ae0, af0;
  logic [AW:0]   count1, count0;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [W-1:0] model [$];
  logic [W-1:0] exp_q1;

  always #5 clk = ~clk;

  std_sync_fifo #(
    .WIDTH(W), .DEPTH(D), .ALMOST_FULL_COUNT(4),
    .ALMOST_EMPTY_COUNT(1), .LATENCY(1)
  ) u_lat1 (
    .rst(rst), .clk(clk), .push(push), .pop(pop), .d(d), .q(q1),
    .full(full1), .empty(empty1), .count(count1),
    .almost_empty(ae1), .almost_full(af1)
  );

  std_sync_fifo #(
    .WIDTH(W), .DEPTH(D), .ALMOST_FULL_COUNT(4),
    .ALMOST_EMPTY_COUNT(1), .LATENCY(0)
  ) u_lat0 (
    .rst(rst), .clk(clk), .push(push), .pop(pop), .d(d), .q(q0),
    .full(full0), .empty(empty0), .count(count0),
    .almost_empty(ae0), .almost_full(af0)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (txn %0d): observed=%0h expected=%0h", tag, txn, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = model.size();
    chk("lat1.count", W'(count1), W'(n));
    chk("lat1.empty", W'(empty1), W'(n == 0));
    chk("lat1.full",  W'(full1),  W'(n == D));
    chk("lat1.almost_empty", W'(ae1), W'(n <= 1));
    chk("lat1.almost_full",  W'(af1), W'(n >= D - 4));
    chk("lat1.q", q1, exp_q1);
    chk("lat0.count", W'(count0), W'(n));
    chk("lat0.empty", W'(empty0), W'(n == 0));
    chk("lat0.full",  W'(full0),  W'(n == D));
    chk("lat0.almost_empty", W'(ae0), W'(n <= 1));
    chk("lat0.almost_full",  W'(af0), W'(n >= D - 4));
    if (n > 0) begin
      chk("lat0.q", q0, model[0]);
    end
  endtask

  // One clock cycle: inputs applied at the falling edge, model advanced with
  // the FIFO rules, outputs compared at the next falling edge.
  task automatic step(input logic r, input logic p, input logic o,
                      input logic [W-1:0] dv);
    int n;
    bit pe, pu;
    n    = model.size();
    rst  = r;
    push = p;
    pop  = o;
    d    = dv;
    if (r) begin
      model.delete();
      exp_q1 = '0;
    end else begin
      pe = o && (n > 0);
      pu = p && ((n < D) || pe);
      if (pe) exp_q1 = model.pop_front();
      if (pu) model.push_back(dv);
    end
    @(posedge clk);
    @(negedge clk);
    txn++;
    $display("txn %0d: rst=%0b push=%0b pop=%0b d=%0h -> count=%0d q1=%0h q0=%0h",
             txn, r, p, o, dv, count1, q1, q0);
    check_all();
  endtask

  initial begin
    int bias;
    logic r, p, o;
    exp_q1 = '0;
    @(negedge clk);

    // Reset, then idle.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 64'hDEAD);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Ordering with one-cycle read latency.
    step(1'b0, 1'b1, 1'b0, 64'h11);
    step(1'b0, 1'b1, 1'b0, 64'h22);
    step(1'b0, 1'b1, 1'b0, 64'h33);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0);

    // Fill to full, overflow attempt, full push+pop, drain.
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, 64'hA000 + 64'(i));
    step(1'b0, 1'b1, 1'b0, 64'hBAD);
    step(1'b0, 1'b1, 1'b1, 64'hC0DE);
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b1, '0);

    // Fall-through read, pop to empty, pop while empty.
    step(1'b0, 1'b1, 1'b0, 64'hAB);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    // Push+pop on empty: only the push lands.
    step(1'b0, 1'b1, 1'b1, 64'h5A5A);
    step(1'b0, 1'b0, 1'b1, '0);

    // Reset with count=10 while pushing.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 64'hD000 + 64'(i));
    step(1'b1, 1'b1, 1'b0, 64'hE0E0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Randomized traffic with a drifting fill bias.
    bias = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) bias = $urandom_range(15, 85);
      p = ($urandom_range(99) < bias);
      o = ($urandom_range(99) < (100 - bias));
      r = ($urandom_range(399) == 0);
      step(r, p, o, {$urandom, $urandom});
    end
    step(1'b0, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
